flu_wb_arbiter: RTL and testbench

Parametrised writeback arbiter for the fixed-latency execute path. It merges results from NR_CH single-cycle and sequential functional units (ALU, branch, CSR buffer, multiplier, future FUs) onto one registered scoreboard writeback port. It replaces the single priority result mux with per-channel buffering, a selectable arbitration mode and back-pressure, so a stalled writeback never drops a result.

---
 rtl/flu_wb_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_flu_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: merges NR_CH fixed-latency FU result channels onto one registered writeback port.
// Latency: push in cycle c -> wb_valid_o in c+2 when uncontended; sustains 1 result/cycle.
// Backpressure: per-channel FIFO, ch_ready_o = !full from state only; FLU_WB_ARB_PERF_EN adds stall/conflict counters.

module flu_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign do_push    = push_i && !full_o && !flush_i;
    assign do_pop     = pop_i && !empty_o && !flush_i;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

module flu_wb_arbiter #(
    parameter int unsigned NR_CH      = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned TID_W      = 3,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PRIO_MODE  = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [NR_CH-1:0]          ch_valid_i,
    output logic [NR_CH-1:0]          ch_ready_o,
    input  logic [NR_CH*DATA_W-1:0]   ch_result_i,
    input  logic [NR_CH*TID_W-1:0]    ch_tid_i,
    input  logic [NR_CH-1:0]          ch_ex_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [DATA_W-1:0]         wb_result_o,
    output logic [TID_W-1:0]          wb_tid_o,
    output logic                      wb_ex_o,
    output logic [$clog2(NR_CH)-1:0]  wb_ch_o,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               conflict_cnt_o
);
    localparam int unsigned CH_W = $clog2(NR_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NR_CH - 1);

    typedef struct packed {
        logic              ex;
        logic [TID_W-1:0]  tid;
        logic [DATA_W-1:0] result;
    } wb_ent_t;

    wb_ent_t           push_dat [NR_CH];
    wb_ent_t           head_dat [NR_CH];
    logic [NR_CH-1:0]  fifo_full;
    logic [NR_CH-1:0]  fifo_empty;
    logic [NR_CH-1:0]  non_empty;
    logic [NR_CH-1:0]  push_vld;
    logic [NR_CH-1:0]  pop_vld;

    wb_ent_t           wb_q;
    logic              wb_valid_q;
    logic [CH_W-1:0]   wb_ch_q;
    logic [CH_W-1:0]   rr_ptr_q;

    logic              out_free;
    logic              gnt_found;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    wb_ent_t           gnt_dat;
    int                cand;

    for (genvar g = 0; g < NR_CH; g++) begin : g_ch
        assign push_dat[g] = '{ex:     ch_ex_i[g],
                               tid:    ch_tid_i[g*TID_W +: TID_W],
                               result: ch_result_i[g*DATA_W +: DATA_W]};
        assign push_vld[g] = ch_valid_i[g] && !fifo_full[g] && !flush_i;
        assign pop_vld[g]  = gnt_vld && (gnt_idx == CH_W'(g));

        flu_wb_fifo #(
            .WIDTH ($bits(wb_ent_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .push_i     (push_vld[g]),
            .push_dat_i (push_dat[g]),
            .pop_i      (pop_vld[g]),
            .head_dat_o (head_dat[g]),
            .full_o     (fifo_full[g]),
            .empty_o    (fifo_empty[g])
        );
    end

    assign ch_ready_o = ~fifo_full;
    assign non_empty  = ~fifo_empty;
    assign out_free   = !wb_valid_q || wb_ready_i;
    assign gnt_vld    = gnt_found && out_free && !flush_i;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (PRIO_MODE == 1) begin
            // Descending scan leaves the lowest non-empty index selected.
            for (int i = int'(NR_CH) - 1; i >= 0; i--) begin
                if (non_empty[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = CH_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= int'(NR_CH); k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= int'(NR_CH)) cand = cand - int'(NR_CH);
                if (!gnt_found && non_empty[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = CH_W'(cand);
                end
            end
        end
    end

    always_comb begin
        gnt_dat = head_dat[0];
        for (int i = 1; i < int'(NR_CH); i++) begin
            if (gnt_idx == CH_W'(i)) gnt_dat = head_dat[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            wb_ch_q    <= '0;
            rr_ptr_q   <= LAST_CH;
        end else if (flush_i) begin
            // An in-flight writeback is squashed along with the FIFOs.
            wb_valid_q <= 1'b0;
            rr_ptr_q   <= LAST_CH;
        end else begin
            if (out_free) wb_valid_q <= gnt_vld;
            if (gnt_vld) begin
                wb_q     <= gnt_dat;
                wb_ch_q  <= gnt_idx;
                rr_ptr_q <= gnt_idx;
            end
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_result_o = wb_q.result;
    assign wb_tid_o    = wb_q.tid;
    assign wb_ex_o     = wb_q.ex;
    assign wb_ch_o     = wb_ch_q;

`ifdef FLU_WB_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (wb_valid_q && !wb_ready_i && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (gnt_vld && ($countones(non_empty) > 1) && (conflict_cnt_q != '1))
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign stall_cnt_o    = '0;
    assign conflict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus; expectations are hand-derived.
module tb_flu_wb_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   ch_valid;
    logic [3:0]   ch_ex;
    logic [255:0] ch_result;
    logic [11:0]  ch_tid;
    logic         wb_ready;

    logic [3:0]   rr_ready,  fp_ready;
    logic         rr_valid,  fp_valid;
    logic [63:0]  rr_result, fp_result;
    logic [2:0]   rr_tid,    fp_tid;
    logic         rr_ex,     fp_ex;
    logic [1:0]   rr_ch,     fp_ch;
    logic [31:0]  rr_stall,  fp_stall;
    logic [31:0]  rr_conf,   fp_conf;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef FLU_WB_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    flu_wb_arbiter #(.NR_CH(4), .DATA_W(64), .TID_W(3), .FIFO_DEPTH(2), .PRIO_MODE(0)) dut_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .ch_valid_i(ch_valid), .ch_ready_o(rr_ready), .ch_result_i(ch_result),
        .ch_tid_i(ch_tid), .ch_ex_i(ch_ex),
        .wb_valid_o(rr_valid), .wb_ready_i(wb_ready), .wb_result_o(rr_result),
        .wb_tid_o(rr_tid), .wb_ex_o(rr_ex), .wb_ch_o(rr_ch),
        .stall_cnt_o(rr_stall), .conflict_cnt_o(rr_conf)
    );

    flu_wb_arbiter #(.NR_CH(4), .DATA_W(64), .TID_W(3), .FIFO_DEPTH(2), .PRIO_MODE(1)) dut_fp (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .ch_valid_i(ch_valid), .ch_ready_o(fp_ready), .ch_result_i(ch_result),
        .ch_tid_i(ch_tid), .ch_ex_i(ch_ex),
        .wb_valid_o(fp_valid), .wb_ready_i(wb_ready), .wb_result_o(fp_result),
        .wb_tid_o(fp_tid), .wb_ex_o(fp_ex), .wb_ch_o(fp_ch),
        .stall_cnt_o(fp_stall), .conflict_cnt_o(fp_conf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [63:0] r, input logic [2:0] t, input logic e);
        ch_result[i*64 +: 64] = r;
        ch_tid[i*3 +: 3]      = t;
        ch_ex[i]              = e;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        ch_valid  = '0;
        ch_ex     = '0;
        ch_result = '0;
        ch_tid    = '0;
        wb_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid",  64'(rr_valid),  64'd0);
        check("rst_result", rr_result,      64'd0);
        check("rst_tid",    64'(rr_tid),    64'd0);
        check("rst_ch",     64'(rr_ch),     64'd0);
        check("rst_stall",  64'(rr_stall),  64'd0);
        check("rst_conf",   64'(rr_conf),   64'd0);
        check("rst_fp_vld", 64'(fp_valid),  64'd0);
        rst = 1'b0;
        check("rst_ready",  64'(rr_ready),  64'hF);

        // Single push on ch1: visible two cycles later for exactly one cycle
        set_ch(1, 64'hDEAD, 3'd5, 1'b0);
        ch_valid = 4'b0010;
        tick();
        ch_valid = '0;
        check("single_c1_valid", 64'(rr_valid), 64'd0);
        tick();
        check("single_valid",  64'(rr_valid),  64'd1);
        check("single_result", rr_result,      64'hDEAD);
        check("single_tid",    64'(rr_tid),    64'd5);
        check("single_ch",     64'(rr_ch),     64'd1);
        check("single_ex",     64'(rr_ex),     64'd0);
        tick();
        check("single_gone",   64'(rr_valid),  64'd0);

        // All four channels at once: round-robin from channel 0
        do_flush();
        for (int i = 0; i < 4; i++) set_ch(i, 64'(32'h100 + i), 3'(i), (i == 2));
        ch_valid = 4'hF;
        tick();
        ch_valid = '0;
        check("rr_ready", 64'(rr_ready), 64'hF);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_valid%0d", i),  64'(rr_valid), 64'd1);
            check($sformatf("rr_ch%0d", i),     64'(rr_ch),    64'(i));
            check($sformatf("rr_result%0d", i), rr_result,     64'(32'h100 + i));
            check($sformatf("rr_ex%0d", i),     64'(rr_ex),    64'(i == 2));
            tick();
        end
        check("rr_drained", 64'(rr_valid), 64'd0);
        check("rr_conflict", 64'(rr_conf), PERF ? 64'd3 : 64'd0);
        check("fp_conflict", 64'(fp_conf), PERF ? 64'd3 : 64'd0);

        // Fixed priority: ch0 starves ch2, ch2 fills after two accepts, then drains intact
        do_flush();
        ch_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 64'(32'hA00 + k), 3'(k), 1'b0);
            set_ch(2, 64'(32'hB00 + k), 3'(4 + k), 1'b0);
            tick();
            if (k == 0) begin
                check("fp_first_valid",  64'(fp_valid),    64'd0);
                check("fp_ready2_open",  64'(fp_ready[2]), 64'd1);
            end else begin
                check($sformatf("fp_a%0d", k - 1),  fp_result,          64'(32'hA00 + k - 1));
                check($sformatf("fp_ch_k%0d", k),   64'(fp_ch),         64'd0);
                check($sformatf("fp_ready2_k%0d", k), 64'(fp_ready[2]), 64'd0);
            end
        end
        ch_valid = '0;
        tick();
        check("fp_a3",          fp_result,          64'hA03);
        check("fp_ready2_hold", 64'(fp_ready[2]),   64'd0);
        tick();
        check("fp_b0",          fp_result,          64'hB00);
        check("fp_b0_ch",       64'(fp_ch),         64'd2);
        check("fp_b0_tid",      64'(fp_tid),        64'd4);
        check("fp_b0_ex",       64'(fp_ex),         64'd0);
        check("fp_ready2_back", 64'(fp_ready[2]),   64'd1);
        tick();
        check("fp_b1",          fp_result,          64'hB01);
        check("fp_b1_tid",      64'(fp_tid),        64'd5);
        tick();
        check("fp_drained",     64'(fp_valid),      64'd0);
        for (int k = 0; k < 6; k++) tick();

        // Stalled writeback holds for five cycles, then is consumed once
        do_flush();
        wb_ready = 1'b0;
        set_ch(3, 64'h1234, 3'd6, 1'b0);
        ch_valid = 4'b1000;
        tick();
        ch_valid = '0;
        tick();
        for (int j = 0; j < 5; j++) begin
            check($sformatf("stall_valid%0d", j),  64'(rr_valid), 64'd1);
            check($sformatf("stall_result%0d", j), rr_result,     64'h1234);
            check($sformatf("stall_ch%0d", j),     64'(rr_ch),    64'd3);
            check($sformatf("stall_tid%0d", j),    64'(rr_tid),   64'd6);
            tick();
        end
        check("stall_still_valid", 64'(rr_valid), 64'd1);
        check("stall_cnt",    64'(rr_stall), PERF ? 64'd5 : 64'd0);
        check("fp_stall_cnt", 64'(fp_stall), PERF ? 64'd5 : 64'd0);
        wb_ready = 1'b1;
        tick();
        check("stall_consumed", 64'(rr_valid), 64'd0);
        tick();
        check("stall_once",     64'(rr_valid), 64'd0);

        // Full ch0 FIFO flushed with a concurrent push: nothing stale ever appears
        wb_ready = 1'b0;
        ch_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_ch(0, 64'(32'hC00 + k), 3'(k), 1'b0);
            tick();
        end
        check("flush_pre_full",  64'(rr_ready[0]), 64'd0);
        check("flush_pre_valid", 64'(rr_valid),    64'd1);
        set_ch(0, 64'hC03, 3'd3, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        ch_valid = '0;
        check("flush_ready0",  64'(rr_ready[0]), 64'd1);
        check("flush_valid",   64'(rr_valid),    64'd0);
        check("flush_fp_valid", 64'(fp_valid),   64'd0);
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("flush_quiet%0d", k),    64'(rr_valid), 64'd0);
            check($sformatf("flush_fp_quiet%0d", k), 64'(fp_valid), 64'd0);
        end

        // Asynchronous reset mid-transfer, then pointer restarts at channel 0
        wb_ready = 1'b0;
        set_ch(2, 64'hBEEF, 3'd2, 1'b1);
        ch_valid = 4'b0100;
        tick();
        ch_valid = '0;
        tick();
        check("arst_pre_valid", 64'(rr_valid), 64'd1);
        check("arst_pre_ch",    64'(rr_ch),    64'd2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid",  64'(rr_valid), 64'd0);
        check("arst_result", rr_result,     64'd0);
        check("arst_tid",    64'(rr_tid),   64'd0);
        check("arst_ex",     64'(rr_ex),    64'd0);
        check("arst_ch",     64'(rr_ch),    64'd0);
        check("arst_stall",  64'(rr_stall), 64'd0);
        check("arst_conf",   64'(rr_conf),  64'd0);
        #2;
        rst = 1'b0;
        tick();
        check("arst_ready", 64'(rr_ready), 64'hF);
        wb_ready = 1'b1;
        set_ch(1, 64'h11, 3'd1, 1'b0);
        set_ch(3, 64'h33, 3'd3, 1'b0);
        ch_valid = 4'b1010;
        tick();
        ch_valid = '0;
        tick();
        check("arst_first_ch",      64'(rr_ch),    64'd1);
        check("arst_first_result",  rr_result,     64'h11);
        tick();
        check("arst_second_ch",     64'(rr_ch),    64'd3);
        check("arst_second_result", rr_result,     64'h33);
        tick();
        check("arst_idle",          64'(rr_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
